register_file: RTL and testbench

- General-purpose register file for the A09 datapath.
- 2^SelectSize registers of DataWidth bits each; default is 8 x 16.
- One synchronous write port and two asynchronous (combinational) read ports.
- Sits between the ALU/data-in mux and the ALU operand inputs; the sequence control matrix drives REG_WE and the select fields.

---
 rtl/register_file.sv | 65 ++++++
 tb/tb_register_file.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/register_file.sv
// -----------------------------------------------------------------------------
// register_file
//
// General-purpose register file for the A09 datapath. It sits between the
// ALU/data-in mux and the ALU operand inputs.
// It holds 2**SelectSize registers, each DataWidth bits wide. It has one
// synchronous write port and two combinational read ports.
//
// Ports
//   Clk       in   1           system clock. Writes happen on its FALLING edge.
//   Reset_N   in   1           asynchronous, active-low clear of every register
//   REG_WE    in   1           write enable, active-low (0 = write, 1 = hold)
//   DIn       in   DataWidth   write data
//   REG_Dst   in   SelectSize  destination register index
//   REG_Src1  in   SelectSize  read port 1 register index
//   REG_Src2  in   SelectSize  read port 2 register index
//   SRC1      out  DataWidth   contents of register REG_Src1
//   SRC2      out  DataWidth   contents of register REG_Src2
//
// The sequence control matrix changes REG_WE, DIn and REG_Dst on or after the
// rising edge. Committing on the falling edge gives those signals half a cycle
// to settle. It also makes the written value visible on the read ports before
// the cycle ends.
//
// The read ports do not bypass DIn. Until the falling edge commits a write,
// the old value of the target register is shown. Register 0 is an ordinary
// register and is not tied to zero.
// -----------------------------------------------------------------------------
module register_file #(
  parameter int DataWidth  = 16,
  parameter int SelectSize = 3
) (
  input  logic                  Clk,
  input  logic                  Reset_N,
  input  logic                  REG_WE,
  input  logic [DataWidth-1:0]  DIn,
  input  logic [SelectSize-1:0] REG_Dst,
  input  logic [SelectSize-1:0] REG_Src1,
  input  logic [SelectSize-1:0] REG_Src2,
  output logic [DataWidth-1:0]  SRC1,
  output logic [DataWidth-1:0]  SRC2
);

  localparam int NumRegs = 1 << SelectSize;

  logic [DataWidth-1:0] regs [NumRegs];

  // Falling-edge write port. The asynchronous clear has priority, so no write
  // can land while Reset_N is low.
  always_ff @(negedge Clk or negedge Reset_N) begin
    if (!Reset_N) begin
      for (int i = 0; i < NumRegs; i++) begin
        regs[i] <= '0;
      end
    end else if (!REG_WE) begin
      regs[REG_Dst] <= DIn;
    end
  end

  // The read ports are pure muxes with no clock latency. Every index value
  // addresses a real register, so no range guard is needed.
  assign SRC1 = regs[REG_Src1];
  assign SRC2 = regs[REG_Src2];

endmodule

// File: tb/tb_register_file.sv
// -----------------------------------------------------------------------------
// tb_register_file
//
// Directed testbench for register_file with the default 8 x 16 size.
// Inputs change 1 time unit after the rising edge. Writes commit on the
// falling edge. Outputs are sampled 1 time unit after the falling edge, or
// between edges for the combinational read checks.
// -----------------------------------------------------------------------------
module tb_register_file;

  localparam int DataWidth  = 16;
  localparam int SelectSize = 3;
  localparam int NumRegs    = 1 << SelectSize;

  logic                  Clk;
  logic                  Reset_N;
  logic                  REG_WE;
  logic [DataWidth-1:0]  DIn;
  logic [SelectSize-1:0] REG_Dst;
  logic [SelectSize-1:0] REG_Src1;
  logic [SelectSize-1:0] REG_Src2;
  logic [DataWidth-1:0]  SRC1;
  logic [DataWidth-1:0]  SRC2;

  int n_cmp;
  int n_fail;

  register_file #(
    .DataWidth (DataWidth),
    .SelectSize(SelectSize)
  ) dut (
    .Clk     (Clk),
    .Reset_N (Reset_N),
    .REG_WE  (REG_WE),
    .DIn     (DIn),
    .REG_Dst (REG_Dst),
    .REG_Src1(REG_Src1),
    .REG_Src2(REG_Src2),
    .SRC1    (SRC1),
    .SRC2    (SRC2)
  );

  // ---------------------------------------------------------------------------
  // Clock and reset
  // ---------------------------------------------------------------------------
  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  // ---------------------------------------------------------------------------
  // Driver tasks
  // ---------------------------------------------------------------------------
  task automatic after_pos();
    @(posedge Clk);
    #1;
  endtask

  task automatic after_neg();
    @(negedge Clk);
    #1;
  endtask

  // Issue one write in the current cycle and drop REG_WE at the next rising edge.
  task automatic write_reg(input int dst, input logic [DataWidth-1:0] data);
    after_pos();
    REG_WE  = 1'b0;
    REG_Dst = SelectSize'(dst);
    DIn     = data;
    after_neg();
    after_pos();
    REG_WE = 1'b1;
  endtask

  // ---------------------------------------------------------------------------
  // Scoreboard check
  // ---------------------------------------------------------------------------
  task automatic check(input string tag, input logic [DataWidth-1:0] obs,
                       input logic [DataWidth-1:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Set both read selects, let the muxes settle, then compare both ports.
  task automatic read_pair(input string tag, input int s1, input int s2,
                           input logic [DataWidth-1:0] e1,
                           input logic [DataWidth-1:0] e2);
    REG_Src1 = SelectSize'(s1);
    REG_Src2 = SelectSize'(s2);
    #1;
    check($sformatf("%s_src1_r%0d", tag, s1), SRC1, e1);
    check($sformatf("%s_src2_r%0d", tag, s2), SRC2, e2);
  endtask

  // ---------------------------------------------------------------------------
  // Directed stimulus
  // ---------------------------------------------------------------------------
  initial begin
    n_cmp    = 0;
    n_fail   = 0;
    Reset_N  = 1'b1;
    REG_WE   = 1'b1;
    DIn      = '0;
    REG_Dst  = '0;
    REG_Src1 = '0;
    REG_Src2 = '0;

    // Reset held across falling edges with a write pending: nothing may land.
    #1;
    Reset_N = 1'b0;
    REG_WE  = 1'b0;
    DIn     = 16'hFFFF;
    REG_Dst = 3'd0;
    after_neg();
    after_neg();
    for (int i = 0; i < NumRegs; i++) begin
      read_pair("reset", i, NumRegs - 1 - i, 16'h0000, 16'h0000);
    end
    after_pos();
    REG_WE  = 1'b1;
    Reset_N = 1'b1;

    // Write R0. The old value is shown before the falling edge, the new one after.
    after_pos();
    REG_WE   = 1'b0;
    DIn      = 16'h00A0;
    REG_Dst  = 3'd0;
    REG_Src1 = 3'd0;
    #1;
    check("r0_before_edge", SRC1, 16'h0000);
    after_neg();
    check("r0_after_edge", SRC1, 16'h00A0);

    // Write R1.
    after_pos();
    DIn      = 16'h000A;
    REG_Dst  = 3'd1;
    REG_Src1 = 3'd1;
    after_neg();
    check("r1_after_edge", SRC1, 16'h000A);

    // Stop writing and reselect R0 between edges. R0 must not have been overwritten.
    after_pos();
    REG_WE   = 1'b1;
    REG_Src1 = 3'd0;
    #1;
    check("r0_kept", SRC1, 16'h00A0);

    // Hold: REG_WE high with data and destination present, for several edges.
    DIn      = 16'h1234;
    REG_Dst  = 3'd2;
    REG_Src2 = 3'd2;
    for (int i = 0; i < 3; i++) after_neg();
    check("hold_r2", SRC2, 16'h0000);

    // Load all registers, then read them in opposite order on the two ports.
    for (int i = 0; i < NumRegs; i++) begin
      write_reg(i, 16'(16'h1111 * (i + 1)));
    end
    for (int i = 0; i < NumRegs; i++) begin
      read_pair("sweep", i, NumRegs - 1 - i,
                16'(16'h1111 * (i + 1)), 16'(16'h1111 * (NumRegs - i)));
    end
    read_pair("alias", 5, 5, 16'h6666, 16'h6666);

    // Destination equals both sources: the old value is shown until the edge.
    after_pos();
    REG_WE   = 1'b0;
    DIn      = 16'hC0DE;
    REG_Dst  = 3'd4;
    REG_Src1 = 3'd4;
    REG_Src2 = 3'd4;
    #1;
    check("dst_alias_pre_src1", SRC1, 16'h5555);
    after_neg();
    check("dst_alias_post_src1", SRC1, 16'hC0DE);
    check("dst_alias_post_src2", SRC2, 16'hC0DE);
    after_pos();
    REG_WE = 1'b1;

    // Asynchronous reset between edges clears the outputs without any clock edge.
    read_pair("pre_areset", 3, 6, 16'h4444, 16'h7777);
    #1;
    Reset_N = 1'b0;
    #1;
    check("areset_src1", SRC1, 16'h0000);
    check("areset_src2", SRC2, 16'h0000);
    after_pos();
    Reset_N = 1'b1;

    // The first write after release lands only in its target register.
    write_reg(3, 16'hBEEF);
    read_pair("post_reset", 3, 6, 16'hBEEF, 16'h0000);
    read_pair("post_reset", 0, 4, 16'h0000, 16'h0000);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  // Watchdog: the run is short. This only guards against a stalled schedule.
  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish within the time limit");
    $fatal(1, "watchdog expired");
  end

endmodule
